// File: rtl/miriscv_pkg.sv
// Shared definitions for the miriscv data memory: FSM encoding, parameter
// defaults and legal ranges, and the byte-lane merge helper.
package miriscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int DEFAULT_LATENCY     = 2;
    localparam int LATENCY_MIN         = 1;
    localparam int LATENCY_MAX         = 15;

    // Replace only the byte lanes whose mask bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/miriscv_data_mem_if.sv
// Load/store-unit to data-memory bus, with requester (master) and memory
// (slave) views.
interface miriscv_data_mem_if;

    // mem_req_i is sampled only while the memory is idle; the transaction ends
    // with a single-cycle mem_ready_o, and mem_err_o/mem_data_o are meaningful
    // in that cycle. The requester drops mem_req_i after ready unless it wants
    // a back-to-back transaction.
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_mask_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    logic        mem_err_o;

    modport master (
        output mem_req_i, mem_we_i, mem_mask_i, mem_addr_i, mem_data_i,
        input  mem_data_o, mem_ready_o, mem_err_o
    );

    modport slave (
        input  mem_req_i, mem_we_i, mem_mask_i, mem_addr_i, mem_data_i,
        output mem_data_o, mem_ready_o, mem_err_o
    );

endinterface

// File: rtl/miriscv_ram_array.sv
// Word-organised storage with per-byte write enables and asynchronous read.
// Contents are intentionally not reset.
module miriscv_ram_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_mask,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_mask[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/miriscv_data_mem.sv
// Fixed-latency data memory for the miriscv load/store unit: accepts one
// request in IDLE, waits LATENCY cycles, then answers with a one-cycle ready.
module miriscv_data_mem
    import miriscv_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic               clk,
    input  logic               reset,
    miriscv_data_mem_if.slave  mem,
    output state_t             o_dbg_state
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_mask;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic          w_accept;
    logic          w_commit;
    logic [31:0]   w_addr;
    logic          w_we;
    logic [3:0]    w_mask;
    logic [31:0]   w_wdata;
    logic          w_oor;
    logic [AW-1:0] w_idx;
    logic          w_ram_we;
    logic [31:0]   w_ram_rdata;
    logic [31:0]   w_resp_data;

    assign w_accept = (r_state == IDLE) && mem.mem_req_i;

    // The commit edge is the one entering RESP; with LATENCY=1 that is the
    // acceptance edge itself, so the live inputs are used instead of latches.
    assign w_commit = (w_accept && (LATENCY == 1)) ||
                      ((r_state == WAIT) && (r_cnt == 4'd1));

    assign w_addr  = (r_state == IDLE) ? mem.mem_addr_i : r_addr;
    assign w_we    = (r_state == IDLE) ? mem.mem_we_i   : r_we;
    assign w_mask  = (r_state == IDLE) ? mem.mem_mask_i : r_mask;
    assign w_wdata = (r_state == IDLE) ? mem.mem_data_i : r_wdata;

    assign w_oor    = (w_addr >= ADDR_LIMIT);
    assign w_idx    = w_addr[2 +: AW];
    assign w_ram_we = w_commit && w_we && !w_oor && !reset;

    // The array reads the pre-write word, so the response merges in the lanes.
    assign w_resp_data = w_oor ? 32'd0 :
                         (w_we ? merge_bytes(w_ram_rdata, w_wdata, w_mask) : w_ram_rdata);

    miriscv_ram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_mask  (w_mask),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (mem.mem_req_i) begin
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_we    <= 1'b0;
            r_mask  <= 4'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr  <= mem.mem_addr_i;
                r_we    <= mem.mem_we_i;
                r_mask  <= mem.mem_mask_i;
                r_wdata <= mem.mem_data_i;
            end
            if (w_commit) begin
                r_rdata <= w_resp_data;
                r_err   <= w_oor;
            end else if (r_state == RESP) begin
                r_err   <= 1'b0;
            end
        end
    end

    assign mem.mem_data_o  = r_rdata;
    assign mem.mem_ready_o = (r_state == RESP);
    assign mem.mem_err_o   = r_err;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_miriscv_data_mem.sv
// Directed bench for miriscv_data_mem: default build plus LATENCY=1 and
// LATENCY=15 builds, all on one clock.
module tb_miriscv_data_mem;
    import miriscv_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    miriscv_data_mem_if bus ();
    miriscv_data_mem_if b1 ();
    miriscv_data_mem_if b15 ();

    state_t dbg_state;
    state_t dbg_state_1;
    state_t dbg_state_15;

    miriscv_data_mem u_dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    miriscv_data_mem #(.LATENCY(1)) u_lat1 (
        .clk         (clk),
        .reset       (reset),
        .mem         (b1.slave),
        .o_dbg_state (dbg_state_1)
    );

    miriscv_data_mem #(.LATENCY(15)) u_lat15 (
        .clk         (clk),
        .reset       (reset),
        .mem         (b15.slave),
        .o_dbg_state (dbg_state_15)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one transaction on the default build, scribbling on the inputs
    // while it is in flight; returns response data/err and cycles to ready.
    task automatic mem_txn(input logic we, input logic [3:0] mask, input logic [31:0] addr,
                           input logic [31:0] data, output logic [31:0] rdata,
                           output logic err, output int lat);
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = we;
        bus.mem_mask_i = mask;
        bus.mem_addr_i = addr;
        bus.mem_data_i = data;
        @(posedge clk); #1;
        lat = 1;
        while (!bus.mem_ready_o && lat < 40) begin
            bus.mem_req_i  = 1'($urandom_range(0, 1));
            bus.mem_we_i   = 1'($urandom_range(0, 1));
            bus.mem_mask_i = 4'($urandom_range(0, 15));
            bus.mem_addr_i = $urandom;
            bus.mem_data_i = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        bus.mem_req_i = 1'b0;
        rdata = bus.mem_data_o;
        err   = bus.mem_err_o;
        @(posedge clk); #1;
        check_eq("ready_one_cycle", 32'(bus.mem_ready_o), 32'd0);
    endtask

    task automatic do_txn(input string tag, input logic we, input logic [3:0] mask,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lt;
        logic [31:0] exp;
        exp_q.push_back(exp_data);
        mem_txn(we, mask, addr, data, rd, er, lt);
        exp = exp_q.pop_front();
        check_eq({tag, "_data"}, rd, exp);
        check_eq({tag, "_err"}, 32'(er), 32'(exp_err));
        check_eq({tag, "_lat"}, 32'(lt), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rdy_cnt;
        int          first_rdy;
        int          last_rdy;
        int          consec;
        int          n;
        logic        prev_rdy;
        logic        rdy_seen;
        logic [31:0] second_data;

        reset = 1'b1;
        bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_mask_i = 4'd0;
        bus.mem_addr_i = 32'h40; bus.mem_data_i = 32'd0;
        b1.mem_req_i = 1'b0; b1.mem_we_i = 1'b0; b1.mem_mask_i = 4'd0;
        b1.mem_addr_i = 32'd0; b1.mem_data_i = 32'd0;
        b15.mem_req_i = 1'b0; b15.mem_we_i = 1'b0; b15.mem_mask_i = 4'd0;
        b15.mem_addr_i = 32'd0; b15.mem_data_i = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(bus.mem_ready_o), 32'd0);
        check_eq("rst_err", 32'(bus.mem_err_o), 32'd0);
        check_eq("rst_data", bus.mem_data_o, 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));

        // Request held through reset is taken on the first free edge.
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("held_req_accept", 32'(dbg_state), 32'(WAIT));
        bus.mem_req_i = 1'b0;
        @(posedge clk); #1;
        check_eq("held_req_ready", 32'(bus.mem_ready_o), 32'd1);
        @(posedge clk); #1;
        check_eq("held_req_idle", 32'(dbg_state), 32'(IDLE));

        do_txn("w10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        do_txn("r10", 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        do_txn("w20_full", 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h11223344, 1'b0);
        do_txn("w20_lane1", 1'b1, 4'h2, 32'h20, 32'h0000AA00, 32'h1122AA44, 1'b0);
        do_txn("r20_a", 1'b0, 4'h0, 32'h20, 32'h0, 32'h1122AA44, 1'b0);
        do_txn("w20_mask0", 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'h1122AA44, 1'b0);
        do_txn("r20_b", 1'b0, 4'h0, 32'h20, 32'h0, 32'h1122AA44, 1'b0);
        do_txn("w20_lane30", 1'b1, 4'h9, 32'h23, 32'hA5000077, 32'hA522AA77, 1'b0);

        // 0x1000 aliases word 0 if the range check is missing.
        do_txn("w00", 1'b1, 4'hF, 32'h0, 32'h01020304, 32'h01020304, 1'b0);
        do_txn("r_oor", 1'b0, 4'h0, 32'h1000, 32'h0, 32'h0, 1'b1);
        do_txn("w_oor", 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b1);
        do_txn("w_last", 1'b1, 4'hF, 32'hFFC, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0);
        do_txn("r00", 1'b0, 4'h0, 32'h0, 32'h0, 32'h01020304, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("data_hold", bus.mem_data_o, 32'h01020304);
        check_eq("err_idle", 32'(bus.mem_err_o), 32'd0);

        // Request held high: write then read of the same word back-to-back.
        bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_mask_i = 4'hF;
        bus.mem_addr_i = 32'h50; bus.mem_data_i = 32'h600DCAFE;
        rdy_cnt = 0; first_rdy = 0; last_rdy = 0; consec = 0;
        prev_rdy = 1'b0; second_data = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (bus.mem_ready_o) begin
                rdy_cnt++;
                if (rdy_cnt == 1) first_rdy = k;
                if (rdy_cnt == 2) second_data = bus.mem_data_o;
                last_rdy = k;
                if (prev_rdy) consec++;
                bus.mem_we_i = 1'b0;
            end
            prev_rdy = bus.mem_ready_o;
        end
        bus.mem_req_i = 1'b0;
        check_eq("b2b_count", 32'(rdy_cnt), 32'd4);
        check_eq("b2b_first", 32'(first_rdy), 32'd2);
        check_eq("b2b_last", 32'(last_rdy), 32'd11);
        check_eq("b2b_consec", 32'(consec), 32'd0);
        check_eq("b2b_read_after_write", second_data, 32'h600DCAFE);
        @(posedge clk); #1;

        // Reset during WAIT of a write aborts it.
        do_txn("w30", 1'b1, 4'hF, 32'h30, 32'h33333333, 32'h33333333, 1'b0);
        bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_mask_i = 4'hF;
        bus.mem_addr_i = 32'h30; bus.mem_data_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        check_eq("abort_in_wait", 32'(dbg_state), 32'(WAIT));
        reset = 1'b1;
        bus.mem_req_i = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_ready", 32'(bus.mem_ready_o), 32'd0);
        check_eq("abort_data", bus.mem_data_o, 32'd0);
        check_eq("abort_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        rdy_seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.mem_ready_o) rdy_seen = 1'b1;
        end
        check_eq("abort_no_pulse", 32'(rdy_seen), 32'd0);
        do_txn("r30", 1'b0, 4'h0, 32'h30, 32'h0, 32'h33333333, 1'b0);

        // LATENCY=1 build.
        b1.mem_req_i = 1'b1; b1.mem_we_i = 1'b1; b1.mem_mask_i = 4'hF;
        b1.mem_addr_i = 32'h8; b1.mem_data_i = 32'h12345678;
        @(posedge clk); #1;
        check_eq("lat1_ready", 32'(b1.mem_ready_o), 32'd1);
        check_eq("lat1_data", b1.mem_data_o, 32'h12345678);
        check_eq("lat1_err", 32'(b1.mem_err_o), 32'd0);
        b1.mem_req_i = 1'b0;
        @(posedge clk); #1;
        check_eq("lat1_ready_drop", 32'(b1.mem_ready_o), 32'd0);
        b1.mem_req_i = 1'b1; b1.mem_we_i = 1'b0;
        rdy_cnt = 0; consec = 0; prev_rdy = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (b1.mem_ready_o) begin
                rdy_cnt++;
                if (prev_rdy) consec++;
            end
            prev_rdy = b1.mem_ready_o;
        end
        b1.mem_req_i = 1'b0;
        check_eq("lat1_hold_count", 32'(rdy_cnt), 32'd3);
        check_eq("lat1_hold_consec", 32'(consec), 32'd0);

        // LATENCY=15 build with input noise while waiting.
        b15.mem_req_i = 1'b1; b15.mem_we_i = 1'b1; b15.mem_mask_i = 4'hF;
        b15.mem_addr_i = 32'h4; b15.mem_data_i = 32'h00C0FFEE;
        @(posedge clk); #1;
        n = 1;
        while (!b15.mem_ready_o && n < 40) begin
            if (n < 13) begin
                b15.mem_req_i  = 1'($urandom_range(0, 1));
                b15.mem_we_i   = 1'($urandom_range(0, 1));
                b15.mem_mask_i = 4'($urandom_range(0, 15));
                b15.mem_addr_i = $urandom;
                b15.mem_data_i = $urandom;
            end else begin
                b15.mem_req_i = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        b15.mem_req_i = 1'b0;
        check_eq("lat15_cycles", 32'(n), 32'd15);
        check_eq("lat15_data", b15.mem_data_o, 32'h00C0FFEE);
        check_eq("lat15_err", 32'(b15.mem_err_o), 32'd0);
        @(posedge clk); #1;
        check_eq("lat15_ready_drop", 32'(b15.mem_ready_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
